// File: rtl/cnn_window_gen.sv
// cnn_window_gen: sliding KH x KW window generator for a raster-order pixel
// stream feeding a CNN kernel.
//
// Pixels arrive one per cycle whenever i_valid is high (no back-pressure).
// KH-1 line buffers hold the previous image lines. A KH x KW shift register
// holds the current window. When the accepted pixel completes a window that
// lies fully inside the image, the packed window is registered on o_fmap and
// o_valid pulses for one cycle.
//
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous reset, active low
//   i_valid      - i_pixel is accepted this cycle
//   i_pixel      - IF_BW-bit pixel, raster order
//   o_fmap       - packed window; entry k = m*KW+n at [k*IF_BW +: IF_BW]
//   o_valid      - o_fmap holds a fresh complete window (one-cycle pulse)
//   o_busy       - a frame is in progress
//   o_frame_done - one-cycle pulse after the last pixel of a frame
module cnn_window_gen #(
    parameter int KW    = 3,
    parameter int KH    = 3,
    parameter int IF_BW = 8,
    parameter int IW    = 8,
    parameter int IH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic [IF_BW-1:0]          i_pixel,
    output logic [KW*KH*IF_BW-1:0]    o_fmap,
    output logic                      o_valid,
    output logic                      o_busy,
    output logic                      o_frame_done
);

    localparam int CW = (IW > 1) ? $clog2(IW) : 1;
    localparam int RW = (IH > 1) ? $clog2(IH) : 1;
    // A single dummy buffer keeps the declarations legal when KH == 1.
    localparam int LB = (KH > 1) ? KH - 1 : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          frame_last;
    logic          win_ready;

    logic [IF_BW-1:0]           line_buf [LB][IW];
    logic [IF_BW-1:0]           win_p0   [KH][KW];
    logic [IF_BW-1:0]           win_next [KH][KW];
    logic [KW*KH*IF_BW-1:0]     fmap_next;
    logic [KW*KH*IF_BW-1:0]     fmap_p1;
    logic                       vld_p1;

    assign col_last   = (col == CW'(IW - 1));
    assign row_last   = (row == RW'(IH - 1));
    assign frame_last = col_last && row_last;
    // The incoming pixel is the bottom-right corner of an in-image window.
    assign win_ready  = (row >= RW'(KH - 1)) && (col >= CW'(KW - 1));

    // ---- stage p0: window shift and packing (combinational next window) ----
    for (genvar m = 0; m < KH; m++) begin : g_row
        for (genvar n = 0; n < KW; n++) begin : g_col
            if (n < KW - 1) begin : g_shift
                assign win_next[m][n] = win_p0[m][n+1];
            end else if (m < KH - 1) begin : g_buf
                // line_buf[m] holds image line (row - KH + 1 + m) at this column
                assign win_next[m][n] = line_buf[m][col];
            end else begin : g_new
                assign win_next[m][n] = i_pixel;
            end
            assign fmap_next[(m*KW+n)*IF_BW +: IF_BW] = win_next[m][n];
        end
    end

    // Line buffers and window are pure data: never reset. Stale contents are
    // harmless because no window is emitted before KH lines have been seen.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            for (int j = 0; j < LB - 1; j++) begin
                line_buf[j][col] <= line_buf[j+1][col];
            end
            line_buf[LB-1][col] <= i_pixel;
            win_p0 <= win_next;
        end
    end

    // ---- stage p1: registered window output and raster counters ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col     <= '0;
            row     <= '0;
            vld_p1  <= 1'b0;
            fmap_p1 <= '0;
        end else begin
            vld_p1 <= i_valid && win_ready;
            if (i_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (win_ready) begin
                    fmap_p1 <= fmap_next;
                end
            end
        end
    end

    assign o_fmap  = fmap_p1;
    assign o_valid = vld_p1;

    // ---- frame control FSM ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        o_busy       = 1'b0;
        o_frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    state_next = frame_last ? S_DONE : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                o_busy = 1'b1;
                if (i_valid && frame_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_frame_done = 1'b1;
                // A pixel arriving here is (0,0) of the next frame.
                if (i_valid) begin
                    state_next = frame_last ? S_DONE : S_ACTIVE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Testbench for cnn_window_gen: a 4x4-image instance and a default 8x8-image
// instance (both 3x3 windows, 8-bit pixels) sharing clock and reset.
module tb_cnn_window_gen;

    logic        clk;
    logic        rst;
    logic        v4, v8;
    logic [7:0]  p4, p8;
    logic [71:0] o_fmap4, o_fmap8;
    logic        o_valid4, o_valid8;
    logic        o_busy4, o_busy8;
    logic        o_done4, o_done8;

    cnn_window_gen #(.KW(3), .KH(3), .IF_BW(8), .IW(4), .IH(4)) dut4 (
        .clk(clk), .rst(rst), .i_valid(v4), .i_pixel(p4),
        .o_fmap(o_fmap4), .o_valid(o_valid4), .o_busy(o_busy4),
        .o_frame_done(o_done4)
    );

    cnn_window_gen dut8 (
        .clk(clk), .rst(rst), .i_valid(v8), .i_pixel(p8),
        .o_fmap(o_fmap8), .o_valid(o_valid8), .o_busy(o_busy8),
        .o_frame_done(o_done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // sampled outputs of the instance driven in the last cycle
    logic        s_valid, s_done, s_busy;
    logic [71:0] s_fmap;

    // reference model state, index 0 = 4x4 instance, 1 = 8x8 instance
    logic [7:0]  img [2][8][8];
    int          mr [2];
    int          mc [2];
    bit          in_frame [2];
    logic [71:0] held [2];
    int          nwin [2];
    int          ndone [2];

    typedef struct {
        bit          vld;
        logic [7:0]  pix;
        bit          exp_valid;
        bit          exp_done;
        bit          exp_busy;
        logic [71:0] exp_fmap;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
        logic [71:0] r;
        int a [9];
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        r = '0;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(a[k]);
        return r;
    endfunction

    function automatic logic [71:0] model_win(input int sel, input int r, input int c);
        logic [71:0] e;
        e = '0;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
                e[(m*3+n)*8 +: 8] = img[sel][r-2+m][c-2+n];
        return e;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mr[s] = 0; mc[s] = 0; in_frame[s] = 0; held[s] = '0;
        end
    endtask

    // one clock cycle on the selected instance; outputs sampled 1 after the edge
    task automatic cycle(input int sel, input bit v, input logic [7:0] p);
        @(negedge clk);
        v4 = 1'b0;
        v8 = 1'b0;
        if (sel == 0) begin v4 = v; p4 = p; end
        else          begin v8 = v; p8 = p; end
        @(posedge clk);
        #1;
        s_valid = (sel == 0) ? o_valid4 : o_valid8;
        s_fmap  = (sel == 0) ? o_fmap4  : o_fmap8;
        s_done  = (sel == 0) ? o_done4  : o_done8;
        s_busy  = (sel == 0) ? o_busy4  : o_busy8;
    endtask

    // one cycle checked against the raster/image model
    task automatic drive(input int sel, input bit v, input logic [7:0] p);
        bit ev, ed;
        int dim;
        dim = (sel == 0) ? 4 : 8;
        cycle(sel, v, p);
        ev = 0;
        ed = 0;
        if (v) begin
            img[sel][mr[sel]][mc[sel]] = p;
            if (mr[sel] >= 2 && mc[sel] >= 2) begin
                ev = 1;
                held[sel] = model_win(sel, mr[sel], mc[sel]);
            end
            ed = (mr[sel] == dim - 1) && (mc[sel] == dim - 1);
            in_frame[sel] = !ed;
            if (mc[sel] == dim - 1) begin
                mc[sel] = 0;
                mr[sel] = (mr[sel] == dim - 1) ? 0 : mr[sel] + 1;
            end else begin
                mc[sel]++;
            end
        end
        chk(sel ? "valid8" : "valid4", s_valid, ev);
        chk(sel ? "fmap8"  : "fmap4",  s_fmap,  held[sel]);
        chk(sel ? "done8"  : "done4",  s_done,  ed);
        chk(sel ? "busy8"  : "busy4",  s_busy,  in_frame[sel]);
        if (s_valid) nwin[sel]++;
        if (s_done)  ndone[sel]++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid4"}, o_valid4, 0);
        chk({tag, "_busy4"},  o_busy4,  0);
        chk({tag, "_done4"},  o_done4,  0);
        chk({tag, "_fmap4"},  o_fmap4,  0);
        chk({tag, "_valid8"}, o_valid8, 0);
        chk({tag, "_busy8"},  o_busy8,  0);
        chk({tag, "_done8"},  o_done8,  0);
        chk({tag, "_fmap8"},  o_fmap8,  0);
    endtask

    initial begin
        logic [71:0] w10, w11, w14, w15;

        rst = 1'b0;
        v4 = 1'b0; v8 = 1'b0; p4 = '0; p8 = '0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // 4x4 frame 0..15 back to back, hand-computed table
        w10 = pack9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        w11 = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
        w14 = pack9(4, 5, 6, 8, 9, 10, 12, 13, 14);
        w15 = pack9(5, 6, 7, 9, 10, 11, 13, 14, 15);
        for (int i = 0; i < 16; i++) begin
            tbl[i].vld = 1; tbl[i].pix = 8'(i);
            tbl[i].exp_valid = 0; tbl[i].exp_done = 0; tbl[i].exp_busy = 1;
            tbl[i].exp_fmap = '0;
        end
        tbl[10].exp_valid = 1; tbl[10].exp_fmap = w10;
        tbl[11].exp_valid = 1; tbl[11].exp_fmap = w11;
        tbl[12].exp_fmap = w11;
        tbl[13].exp_fmap = w11;
        tbl[14].exp_valid = 1; tbl[14].exp_fmap = w14;
        tbl[15].exp_valid = 1; tbl[15].exp_fmap = w15;
        tbl[15].exp_done = 1;  tbl[15].exp_busy = 0;
        tbl[16].vld = 0; tbl[16].pix = 8'h00; tbl[16].exp_valid = 0;
        tbl[16].exp_done = 0; tbl[16].exp_busy = 0; tbl[16].exp_fmap = w15;

        for (int i = 0; i < 17; i++) begin
            cycle(0, tbl[i].vld, tbl[i].pix);
            chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_fmap", i),  s_fmap,  tbl[i].exp_fmap);
            chk($sformatf("tbl%0d_done", i),  s_done,  tbl[i].exp_done);
            chk($sformatf("tbl%0d_busy", i),  s_busy,  tbl[i].exp_busy);
        end
        held[0] = w15;

        // same frame with an idle cycle after every pixel
        nwin[0] = 0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 8'(i));
            drive(0, 1'b0, 8'h00);
        end
        chk("gap_windows", 72'(nwin[0]), 72'(4));
        chk("gap_last_win", s_fmap, w15);

        // two frames back to back, second frame 100..115
        nwin[0] = 0;
        ndone[0] = 0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 8'(i));
            if (i == 15) chk("b2b_done_after_p15", s_done, 1);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 8'(100 + i));
            if (i == 10)
                chk("b2b_f2_first_win", s_fmap,
                    pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));
        end
        drive(0, 1'b0, 8'h00);
        chk("b2b_windows", 72'(nwin[0]), 72'(8));
        chk("b2b_done_pulses", 72'(ndone[0]), 72'(2));

        // reset after pixel 6, then a fresh frame 200..215
        for (int i = 0; i < 7; i++) drive(0, 1'b1, 8'(i));
        @(negedge clk);
        v4 = 1'b0;
        v8 = 1'b0;
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        chk_zero("midrst_hold");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        nwin[0] = 0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 8'(200 + i));
            if (i == 10)
                chk("rst_first_win", s_fmap,
                    pack9(200, 201, 202, 204, 205, 206, 208, 209, 210));
        end
        drive(0, 1'b0, 8'h00);
        chk("rst_windows", 72'(nwin[0]), 72'(4));

        // 8x8 instance: alternating 255 / 0
        nwin[1] = 0;
        ndone[1] = 0;
        for (int i = 0; i < 64; i++) drive(1, 1'b1, (i % 2 == 0) ? 8'hFF : 8'h00);
        drive(1, 1'b0, 8'h00);
        chk("alt_windows", 72'(nwin[1]), 72'(36));
        chk("alt_done_pulses", 72'(ndone[1]), 72'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
